// File: rtl/timer_pkg.sv
// Shared definitions for the timer front-end blocks (countdown timer, stopwatch).
package timer_pkg;

  localparam int unsigned MODULO_DEF = 60;
  localparam int unsigned FIELD_W    = 8;

  typedef enum logic [1:0] {IDLE, RUN, ALARM} ctimer_state_t;

  // Clamp a loaded field into the legal range 0..modulo-1.
  function automatic logic [FIELD_W-1:0] sat_field(input logic [FIELD_W-1:0] v,
                                                   input int unsigned modulo);
    if (32'(v) >= modulo) return FIELD_W'(modulo - 1);
    return v;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: counts 0..DIV-1 while enabled and pulses o_tick on the last count.
module tick_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ctimer.sv
// hh:mm:ss countdown timer with start/stop toggle, done pulse and held alarm.
// Define CTIMER_AUTORELOAD_EN to reload the stored value on expiry instead of alarming.
module ctimer
  import timer_pkg::*;
#(
  parameter int unsigned MODULO = MODULO_DEF,
  parameter int unsigned DIV    = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_ss,
  input  logic               i_load,
  input  logic [FIELD_W-1:0] i_lh,
  input  logic [FIELD_W-1:0] i_lm,
  input  logic [FIELD_W-1:0] i_ls,
  output logic [FIELD_W-1:0] o_th,
  output logic [FIELD_W-1:0] o_tm,
  output logic [FIELD_W-1:0] o_ts,
  output logic               o_running,
  output logic               o_done,
  output logic               o_alarm
);

  localparam logic [FIELD_W-1:0] MAX = FIELD_W'(MODULO - 1);

  ctimer_state_t r_state, w_state_d;
  logic [FIELD_W-1:0] r_h, r_m, r_s, w_h_d, w_m_d, w_s_d;
  logic [FIELD_W-1:0] r_rh, r_rm, r_rs, w_rh_d, w_rm_d, w_rs_d;
  logic [FIELD_W-1:0] w_dh, w_dm, w_ds;
  logic               r_done, w_done_d;
  logic               w_clr, w_tick, w_nonzero, w_dec_zero;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_clr),
    .i_en    (r_state == RUN),
    .o_tick  (w_tick)
  );

  assign w_nonzero = ({r_h, r_m, r_s} != '0);

  // One-step borrow chain; only meaningful while the count is nonzero.
  always_comb begin
    w_ds = r_s - 1'b1;
    w_dm = r_m;
    w_dh = r_h;
    if (r_s == '0) begin
      w_ds = MAX;
      if (r_m == '0) begin
        w_dm = MAX;
        w_dh = r_h - 1'b1;
      end else begin
        w_dm = r_m - 1'b1;
      end
    end
  end

  assign w_dec_zero = ({w_dh, w_dm, w_ds} == '0);

  always_comb begin
    w_state_d = r_state;
    w_h_d     = r_h;
    w_m_d     = r_m;
    w_s_d     = r_s;
    w_rh_d    = r_rh;
    w_rm_d    = r_rm;
    w_rs_d    = r_rs;
    w_done_d  = 1'b0;
    w_clr     = 1'b0;
    if (i_load && (r_state != RUN)) begin
      w_rh_d    = sat_field(i_lh, MODULO);
      w_rm_d    = sat_field(i_lm, MODULO);
      w_rs_d    = sat_field(i_ls, MODULO);
      w_h_d     = w_rh_d;
      w_m_d     = w_rm_d;
      w_s_d     = w_rs_d;
      w_state_d = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_ss && w_nonzero) begin
            w_state_d = RUN;
            w_clr     = 1'b1;
          end
        end
        RUN: begin
          if (i_ss) begin
            w_state_d = IDLE;
          end else if (w_tick) begin
            w_h_d = w_dh;
            w_m_d = w_dm;
            w_s_d = w_ds;
            if (w_dec_zero) begin
              w_done_d = 1'b1;
`ifdef CTIMER_AUTORELOAD_EN
              if ({r_rh, r_rm, r_rs} != '0) begin
                w_h_d = r_rh;
                w_m_d = r_rm;
                w_s_d = r_rs;
              end else begin
                w_state_d = IDLE;
              end
`else
              w_state_d = ALARM;
`endif
            end
          end
        end
        ALARM: begin
          if (i_ss) w_state_d = IDLE;
        end
        default: w_state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_h     <= '0;
      r_m     <= '0;
      r_s     <= '0;
      r_rh    <= '0;
      r_rm    <= '0;
      r_rs    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_h     <= w_h_d;
      r_m     <= w_m_d;
      r_s     <= w_s_d;
      r_rh    <= w_rh_d;
      r_rm    <= w_rm_d;
      r_rs    <= w_rs_d;
      r_done  <= w_done_d;
    end
  end

  assign o_th      = r_h;
  assign o_tm      = r_m;
  assign o_ts      = r_s;
  assign o_done    = r_done;
  assign o_running = (r_state == RUN);
  assign o_alarm   = (r_state == ALARM);

endmodule

// File: tb/tb_ctimer.sv
// Randomized bench for ctimer: two DUTs (DIV=1 and DIV=4) against a total-seconds model.
module tb_ctimer;

  localparam int MOD = 60;
  localparam int M_IDLE = 0, M_RUN = 1, M_ALARM = 2;

  logic       clk, rst, ss, ld;
  logic [7:0] lh, lm, ls;
  logic [7:0] th [2];
  logic [7:0] tm [2];
  logic [7:0] ts [2];
  logic       run [2];
  logic       done [2];
  logic       alarm [2];

  int          total, bad;
  int          mode [2];
  int unsigned rem [2];
  int unsigned rld [2];
  int unsigned ph [2];
  bit          mdone [2];

  ctimer #(.MODULO(60), .DIV(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_ss(ss), .i_load(ld),
    .i_lh(lh), .i_lm(lm), .i_ls(ls),
    .o_th(th[0]), .o_tm(tm[0]), .o_ts(ts[0]),
    .o_running(run[0]), .o_done(done[0]), .o_alarm(alarm[0])
  );

  ctimer #(.MODULO(60), .DIV(4)) u_dut4 (
    .i_clk(clk), .i_reset(rst), .i_ss(ss), .i_load(ld),
    .i_lh(lh), .i_lm(lm), .i_ls(ls),
    .o_th(th[1]), .o_tm(tm[1]), .o_ts(ts[1]),
    .o_running(run[1]), .o_done(done[1]), .o_alarm(alarm[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v);
    return (v >= MOD) ? MOD - 1 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i] = M_IDLE; rem[i] = 0; rld[i] = 0; ph[i] = 0; mdone[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int unsigned dv;
      dv = (i == 0) ? 1 : 4;
      mdone[i] = 0;
      if (ld && mode[i] != M_RUN) begin
        rld[i]  = (sat(lh) * MOD + sat(lm)) * MOD + sat(ls);
        rem[i]  = rld[i];
        mode[i] = M_IDLE;
      end else if (mode[i] == M_IDLE) begin
        if (ss && rem[i] != 0) begin
          mode[i] = M_RUN;
          ph[i]   = 0;
        end
      end else if (mode[i] == M_RUN) begin
        if (ss) begin
          mode[i] = M_IDLE;
        end else begin
          ph[i]++;
          if (ph[i] == dv) begin
            ph[i] = 0;
            rem[i]--;
            if (rem[i] == 0) begin
              mdone[i] = 1;
`ifdef CTIMER_AUTORELOAD_EN
              if (rld[i] != 0) rem[i] = rld[i];
              else mode[i] = M_IDLE;
`else
              mode[i] = M_ALARM;
`endif
            end
          end
        end
      end else if (ss) begin
        mode[i] = M_IDLE;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("th%0d", i), th[i], rem[i] / (MOD * MOD));
      check_eq($sformatf("tm%0d", i), tm[i], (rem[i] / MOD) % MOD);
      check_eq($sformatf("ts%0d", i), ts[i], rem[i] % MOD);
      check_eq($sformatf("running%0d", i), run[i], mode[i] == M_RUN);
      check_eq($sformatf("done%0d", i), done[i], mdone[i]);
      check_eq($sformatf("alarm%0d", i), alarm[i], mode[i] == M_ALARM);
    end
  endtask

  // Called at a falling edge: drive inputs, take one rising edge, compare.
  task automatic cyc(input bit s, input bit l, input int h, input int m, input int sec);
    ss = s; ld = l; lh = 8'(h); lm = 8'(m); ls = 8'(sec);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int n_done, first_done;
    total = 0; bad = 0;
    rst = 1'b1; ss = 1'b0; ld = 1'b0; lh = '0; lm = '0; ls = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // 00:01:02 at DIV=1 must expire exactly 62 edges after the ss edge.
    cyc(0, 1, 0, 1, 2);
    cyc(1, 0, 0, 0, 0);
    n_done = 0; first_done = 0;
    for (int n = 1; n <= 300; n++) begin
      cyc(0, 0, 0, 0, 0);
      if (done[0]) begin
        n_done++;
        if (first_done == 0) first_done = n;
      end
    end
    check_eq("done_count", n_done, 1);
    check_eq("done_edge", first_done, 62);
    check_eq("alarm_held", alarm[0], 1);

    // Hour borrow, then pause/resume.
    cyc(0, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);

    // Saturating load, then ss on zero.
    cyc(0, 1, 75, 99, 60);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Load ignored in RUN, then asynchronous reset mid-RUN.
    cyc(0, 1, 0, 0, 30);
    cyc(1, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 5);
    repeat (5) cyc(0, 0, 0, 0, 0);
    ss = 1'b0; ld = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all();

    for (int k = 0; k < 4000; k++) begin
      bit s, l;
      int h, m, sec;
      s   = ($urandom_range(0, 15) == 0);
      l   = ($urandom_range(0, 24) == 0);
      h   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : 0;
      m   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 70) : 0;
      sec = $urandom_range(0, 70);
      cyc(s, l, h, m, sec);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
